// File: rtl/fifo_counted_pkg.sv
// Shared defaults, size helpers and count-update encoding for the counted FIFO.
package fifo_counted_pkg;

   localparam int DEF_DATA_SIZE      = 8;
   localparam int DEF_ADDR_SPACE_EXP = 4;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   function automatic int depth_of(input int addr_exp);
      return 1 << addr_exp;
   endfunction

   // One extra bit over the address so full and empty are distinguishable.
   function automatic int ptr_width(input int addr_exp);
      return addr_exp + 1;
   endfunction

endpackage

// File: rtl/fifo_counted_regfile.sv
// Storage array for the counted FIFO: synchronous write, asynchronous read.
module fifo_regfile
   import fifo_counted_pkg::*;
#(
   parameter int DATA_SIZE      = DEF_DATA_SIZE,
   parameter int ADDR_SPACE_EXP = DEF_ADDR_SPACE_EXP
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [ADDR_SPACE_EXP-1:0] wr_addr,
   input  logic [DATA_SIZE-1:0]      wr_data,
   input  logic [ADDR_SPACE_EXP-1:0] rd_addr,
   output logic [DATA_SIZE-1:0]      rd_data
);

   logic [DATA_SIZE-1:0] mem_q [depth_of(ADDR_SPACE_EXP)];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_counted.sv
// Synchronous FIFO with occupancy count, almost flags, sticky errors, flush and
// optional registered read port; all flags are registered from the next count.
module fifo_counted
   import fifo_counted_pkg::*;
#(
   parameter int DATA_SIZE          = DEF_DATA_SIZE,
   parameter int ADDR_SPACE_EXP     = DEF_ADDR_SPACE_EXP,
   parameter int ALMOST_FULL_LEVEL  = 12,
   parameter int ALMOST_EMPTY_LEVEL = 2,
   parameter int REGISTERED_OUT     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      clear_errors,
   input  logic                      write_to_fifo,
   input  logic                      read_from_fifo,
   input  logic [DATA_SIZE-1:0]      write_data_in,
   output logic [DATA_SIZE-1:0]      read_data_out,
   output logic [ADDR_SPACE_EXP:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_empty,
   output logic                      almost_full,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int DEPTH = depth_of(ADDR_SPACE_EXP);
   localparam int PW    = ptr_width(ADDR_SPACE_EXP);
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_LEVEL);
   localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY_LEVEL);

   if (ALMOST_FULL_LEVEL < 0 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_counted: ALMOST_FULL_LEVEL outside 0..depth");
   end
   if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH) begin : g_bad_ae
      $error("fifo_counted: ALMOST_EMPTY_LEVEL outside 0..depth");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic          empty_q, empty_d, full_q, full_d;
   logic          almost_empty_q, almost_empty_d, almost_full_q, almost_full_d;
   logic          overflow_q, overflow_d, underflow_q, underflow_d;
   logic          rd_ok, wr_ok, mem_we;
   logic [DATA_SIZE-1:0] mem_rdata;
   cnt_op_e       cnt_op;

   always_comb begin
      rd_ok  = read_from_fifo & ~empty_q;
      // A write into a full FIFO is fine when a read frees the head slot this edge.
      wr_ok  = write_to_fifo & (~full_q | read_from_fifo);
      mem_we = wr_ok & ~flush;

      cnt_op = CNT_HOLD;
      if (wr_ok && !rd_ok) begin
         cnt_op = CNT_INC;
      end else if (rd_ok && !wr_ok) begin
         cnt_op = CNT_DEC;
      end

      wr_ptr_d = wr_ptr_q + PW'(wr_ok);
      rd_ptr_d = rd_ptr_q + PW'(rd_ok);
      case (cnt_op)
         CNT_INC: count_d = count_q + PW'(1);
         CNT_DEC: count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase

      // Set wins over clear_errors in the same cycle.
      overflow_d  = (overflow_q & ~clear_errors) | (write_to_fifo & ~wr_ok);
      underflow_d = (underflow_q & ~clear_errors) | (read_from_fifo & empty_q);

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end

      empty_d        = (count_d == '0);
      full_d         = (count_d == DEPTH_C);
      almost_empty_d = (count_d <= AE_C);
      almost_full_d  = (count_d >= AF_C);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         empty_q        <= 1'b1;
         full_q         <= 1'b0;
         almost_empty_q <= 1'b1;
         almost_full_q  <= 1'b0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         empty_q        <= empty_d;
         full_q         <= full_d;
         almost_empty_q <= almost_empty_d;
         almost_full_q  <= almost_full_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   fifo_regfile #(
      .DATA_SIZE      (DATA_SIZE),
      .ADDR_SPACE_EXP (ADDR_SPACE_EXP)
   ) u_regfile (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr_q[ADDR_SPACE_EXP-1:0]),
      .wr_data (write_data_in),
      .rd_addr (rd_ptr_q[ADDR_SPACE_EXP-1:0]),
      .rd_data (mem_rdata)
   );

   if (REGISTERED_OUT != 0) begin : g_reg_out
      logic [DATA_SIZE-1:0] rdata_q, rdata_d;

      // Head word is captured before a same-edge write can overwrite it.
      always_comb begin
         rdata_d = rdata_q;
         if (rd_ok && !flush) begin
            rdata_d = mem_rdata;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rdata_q <= '0;
         end else begin
            rdata_q <= rdata_d;
         end
      end

      assign read_data_out = rdata_q;
   end else begin : g_show_ahead
      assign read_data_out = mem_rdata;
   end

   assign count        = count_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = almost_empty_q;
   assign almost_full  = almost_full_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_counted.sv
// Directed bench: depth-4 FIFO in show-ahead and registered-read variants fed the same stimulus.
module tb_fifo_counted;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush, clear_errors, write_to_fifo, read_from_fifo;
   logic [7:0] write_data_in;

   logic [7:0] rd_s, rd_r;
   logic [2:0] cnt_s, cnt_r;
   logic       e_s, f_s, ae_s, af_s, o_s, u_s;
   logic       e_r, f_r, ae_r, af_r, o_r, u_r;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_counted #(.DATA_SIZE(8), .ADDR_SPACE_EXP(2), .ALMOST_FULL_LEVEL(3),
                  .ALMOST_EMPTY_LEVEL(1), .REGISTERED_OUT(0)) u_show (
      .clk(clk), .reset(reset), .flush(flush), .clear_errors(clear_errors),
      .write_to_fifo(write_to_fifo), .read_from_fifo(read_from_fifo),
      .write_data_in(write_data_in), .read_data_out(rd_s), .count(cnt_s),
      .empty(e_s), .full(f_s), .almost_empty(ae_s), .almost_full(af_s),
      .overflow(o_s), .underflow(u_s));

   fifo_counted #(.DATA_SIZE(8), .ADDR_SPACE_EXP(2), .ALMOST_FULL_LEVEL(3),
                  .ALMOST_EMPTY_LEVEL(1), .REGISTERED_OUT(1)) u_reg (
      .clk(clk), .reset(reset), .flush(flush), .clear_errors(clear_errors),
      .write_to_fifo(write_to_fifo), .read_from_fifo(read_from_fifo),
      .write_data_in(write_data_in), .read_data_out(rd_r), .count(cnt_r),
      .empty(e_r), .full(f_r), .almost_empty(ae_r), .almost_full(af_r),
      .overflow(o_r), .underflow(u_r));

   typedef struct {
      logic       fl, ce, wr, rd;
      logic [7:0] wd;
      logic       cd;
      logic [7:0] xd;
      logic [2:0] xc;
      logic       xe, xf, xae, xaf, xo, xu;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [2:0] xc, input logic xe, input logic xf,
                            input logic xae, input logic xaf, input logic xo, input logic xu);
      chk({tag, " count"}, cnt_s, xc);
      chk({tag, " empty"}, e_s, xe);
      chk({tag, " full"}, f_s, xf);
      chk({tag, " almost_empty"}, ae_s, xae);
      chk({tag, " almost_full"}, af_s, xaf);
      chk({tag, " overflow"}, o_s, xo);
      chk({tag, " underflow"}, u_s, xu);
      chk({tag, " reg count"}, cnt_r, xc);
   endtask

   initial begin
      //            fl ce wr rd  wd    cd xd     xc e f ae af o u
      vecs.push_back('{0,0,1,0, 8'hA1, 0,8'h00, 1,0,0,1,0,0,0});
      vecs.push_back('{0,0,1,0, 8'hA2, 0,8'h00, 2,0,0,0,0,0,0});
      vecs.push_back('{0,0,1,0, 8'hA3, 0,8'h00, 3,0,0,0,1,0,0});
      vecs.push_back('{0,0,1,0, 8'hA4, 0,8'h00, 4,0,1,0,1,0,0});
      vecs.push_back('{0,0,1,0, 8'hFF, 0,8'h00, 4,0,1,0,1,1,0}); // overflow
      vecs.push_back('{0,1,0,0, 8'h00, 0,8'h00, 4,0,1,0,1,0,0}); // clear
      vecs.push_back('{0,0,1,1, 8'hB0, 1,8'hA1, 4,0,1,0,1,0,0}); // rd+wr at full
      vecs.push_back('{0,0,0,1, 8'h00, 1,8'hA2, 3,0,0,0,1,0,0});
      vecs.push_back('{0,0,0,1, 8'h00, 1,8'hA3, 2,0,0,0,0,0,0});
      vecs.push_back('{0,0,0,1, 8'h00, 1,8'hA4, 1,0,0,1,0,0,0});
      vecs.push_back('{0,0,0,1, 8'h00, 1,8'hB0, 0,1,0,1,0,0,0});
      vecs.push_back('{0,0,1,1, 8'hC5, 0,8'h00, 1,0,0,1,0,0,1}); // rd+wr at empty
      vecs.push_back('{0,0,0,1, 8'h00, 1,8'hC5, 0,1,0,1,0,0,1});
      vecs.push_back('{0,1,0,1, 8'h00, 0,8'h00, 0,1,0,1,0,0,1}); // set beats clear
      vecs.push_back('{0,0,1,0, 8'hD1, 0,8'h00, 1,0,0,1,0,0,1});
      vecs.push_back('{0,0,1,0, 8'hD2, 0,8'h00, 2,0,0,0,0,0,1});
      vecs.push_back('{0,0,1,0, 8'hD3, 0,8'h00, 3,0,0,0,1,0,1});
      vecs.push_back('{1,0,1,0, 8'hEE, 0,8'h00, 0,1,0,1,0,0,0}); // flush drops write
      vecs.push_back('{0,0,1,0, 8'h77, 0,8'h00, 1,0,0,1,0,0,0});
      vecs.push_back('{0,0,0,1, 8'h00, 1,8'h77, 0,1,0,1,0,0,0});

      reset = 1'b0;
      flush = 1'b0; clear_errors = 1'b0; write_to_fifo = 1'b0; read_from_fifo = 1'b0;
      write_data_in = 8'h00;
      #12;
      chk_flags("reset", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset reg data", rd_r, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         flush = vecs[i].fl; clear_errors = vecs[i].ce;
         write_to_fifo = vecs[i].wr; read_from_fifo = vecs[i].rd;
         write_data_in = vecs[i].wd;
         if (vecs[i].cd) begin
            #1;
            chk($sformatf("vec%0d head", i), rd_s, vecs[i].xd);
         end
         @(posedge clk);
         #1;
         chk_flags($sformatf("vec%0d", i), vecs[i].xc, vecs[i].xe, vecs[i].xf,
                   vecs[i].xae, vecs[i].xaf, vecs[i].xo, vecs[i].xu);
      end
      @(negedge clk);
      flush = 1'b0; clear_errors = 1'b0; write_to_fifo = 1'b0; read_from_fifo = 1'b0;

      // Overlapped streaming across the pointer wrap.
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         write_to_fifo  = (k < 10);
         write_data_in  = 8'h10 + 8'(k);
         read_from_fifo = (k >= 1);
         #1;
         if (k >= 1) chk($sformatf("stream%0d head", k), rd_s, 8'h10 + 8'(k - 1));
         @(posedge clk);
         #1;
         if (k >= 1) chk($sformatf("stream%0d reg data", k), rd_r, 8'h10 + 8'(k - 1));
         chk($sformatf("stream%0d count", k), cnt_s, (k < 10) ? 3'd1 : 3'd0);
      end
      @(negedge clk);
      write_to_fifo = 1'b0; read_from_fifo = 1'b0;
      @(posedge clk);
      #1;
      chk("reg data hold", rd_r, 8'h19);

      // Asynchronous reset in the middle of a write cycle.
      @(negedge clk);
      read_from_fifo = 1'b1;
      @(posedge clk);
      #1;
      chk("pre-reset underflow", u_s, 1'b1);
      @(negedge clk);
      read_from_fifo = 1'b0; write_to_fifo = 1'b1; write_data_in = 8'h55;
      @(posedge clk);
      #1;
      chk("pre-reset count", cnt_s, 3'd1);
      @(negedge clk);
      write_data_in = 8'h66;
      #2 reset = 1'b0;
      #1;
      chk_flags("async reset", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("async reset reg data", rd_r, 8'h00);
      @(negedge clk);
      write_to_fifo = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset count", cnt_s, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
